// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default-width types for the multi-channel FIFO.
package fifo_pkg;

  localparam int unsigned DEF_CHANNELS   = 4;
  localparam int unsigned DEF_DEPTH      = 32;
  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_SAFE_GUARD = 4;

  // Channel index width; a single channel still gets one select bit.
  function automatic int unsigned calc_chw(input int unsigned channels);
    return (channels > 1) ? unsigned'($clog2(channels)) : 1;
  endfunction

  // Pointer width: entry index plus one wrap bit.
  function automatic int unsigned calc_ptrw(input int unsigned depth);
    return unsigned'($clog2(depth)) + 1;
  endfunction

  typedef logic [calc_chw(DEF_CHANNELS)-1:0] ch_idx_t;
  typedef logic [calc_ptrw(DEF_DEPTH)-1:0]   ptr_t;

endpackage

// File: rtl/fifo_channel_ctrl.sv
// Per-channel pointer pair, occupancy flags and sticky error bits.
module fifo_channel_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned SAFE_GUARD = DEF_SAFE_GUARD,
  localparam int unsigned PTRW       = calc_ptrw(DEPTH),
  localparam int unsigned AW         = PTRW - 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_acc,
  input  logic            rd_acc,
  input  logic            flush,
  input  logic            wr_req_full,
  input  logic            rd_req_empty,
  output logic [AW-1:0]   wr_idx_c,
  output logic [AW-1:0]   rd_idx_c,
  output logic [PTRW-1:0] count_c,
  output logic            full_c,
  output logic            going_full_c,
  output logic            empty_c,
  output logic            going_empty_c,
  output logic            overflow_err,
  output logic            underflow_err
);

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;

  // Flush snaps the read pointer onto the write pointer; the top already
  // suppresses any same-cycle access on a flushed channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (flush) begin
        rd_ptr        <= wr_ptr;
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end else begin
        if (rd_acc) begin
          rd_ptr <= rd_ptr + PTRW'(1);
        end
        overflow_err  <= overflow_err  | wr_req_full;
        underflow_err <= underflow_err | rd_req_empty;
      end
    end
  end

  // Flags depend only on the registered pointers.
  assign count_c       = wr_ptr - rd_ptr;
  assign full_c        = (count_c == PTRW'(DEPTH));
  assign empty_c       = (count_c == '0);
  assign going_full_c  = (count_c >= PTRW'(DEPTH - SAFE_GUARD));
  assign going_empty_c = (count_c <= PTRW'(SAFE_GUARD));
  assign wr_idx_c      = wr_ptr[AW-1:0];
  assign rd_idx_c      = rd_ptr[AW-1:0];

endmodule

// File: rtl/multi_channel_sync_fifo.sv
// Single-clock FIFO with CHANNELS independent queues sharing one memory array,
// one write port, one registered read port and per-channel flush.
module multi_channel_sync_fifo
  import fifo_pkg::*;
#(
  parameter  int unsigned CHANNELS   = DEF_CHANNELS,
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned WIDTH      = DEF_WIDTH,
  parameter  int unsigned SAFE_GUARD = DEF_SAFE_GUARD,
  localparam int unsigned CHW        = calc_chw(CHANNELS),
  localparam int unsigned PTRW       = calc_ptrw(DEPTH)
) (
  input  logic                     clk,
  input  logic                     asynchronous_rst_n,
  input  logic                     wr_en,
  input  logic [CHW-1:0]           wr_ch,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  input  logic [CHW-1:0]           rd_ch,
  input  logic                     flush_en,
  input  logic [CHW-1:0]           flush_ch,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_out_valid,
  output logic [CHW-1:0]           data_out_ch,
  output logic [CHANNELS-1:0]      fifo_full,
  output logic [CHANNELS-1:0]      fifo_going_full,
  output logic [CHANNELS-1:0]      fifo_empty,
  output logic [CHANNELS-1:0]      fifo_going_empty,
  output logic [CHANNELS*PTRW-1:0] fifo_count,
  output logic [CHANNELS-1:0]      overflow_err,
  output logic [CHANNELS-1:0]      underflow_err
);

  localparam int unsigned AW          = PTRW - 1;
  localparam int unsigned MEM_ENTRIES = CHANNELS * DEPTH;

  logic [1:0]          rst_sync_q;
  logic                rst_int_n;

  logic [CHANNELS-1:0] flush_hit;
  logic [CHANNELS-1:0] wr_acc;
  logic [CHANNELS-1:0] rd_acc;
  logic [CHANNELS-1:0] wr_req_full;
  logic [CHANNELS-1:0] rd_req_empty;
  logic [AW-1:0]       wr_idx_c [CHANNELS];
  logic [AW-1:0]       rd_idx_c [CHANNELS];
  logic [AW-1:0]       wr_idx_sel;
  logic [AW-1:0]       rd_idx_sel;
  logic                wr_any;
  logic                rd_any;
  logic [CHW+AW-1:0]   wr_addr;
  logic [CHW+AW-1:0]   rd_addr;

  logic [WIDTH-1:0]    mem [MEM_ENTRIES];

  // Assert asynchronously, release on the second clock edge after deassertion.
  always_ff @(posedge clk or negedge asynchronous_rst_n) begin
    if (!asynchronous_rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Request decode against pre-edge flags; unmatched channel indices hit nothing.
  always_comb begin
    flush_hit    = '0;
    wr_acc       = '0;
    rd_acc       = '0;
    wr_req_full  = '0;
    rd_req_empty = '0;
    wr_idx_sel   = '0;
    rd_idx_sel   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      flush_hit[c] = flush_en && (flush_ch == CHW'(c));
      if (wr_en && (wr_ch == CHW'(c))) begin
        wr_acc[c]      = !fifo_full[c] && !flush_hit[c];
        wr_req_full[c] = fifo_full[c];
        wr_idx_sel     = wr_idx_c[c];
      end
      if (rd_en && (rd_ch == CHW'(c))) begin
        rd_acc[c]       = !fifo_empty[c] && !flush_hit[c];
        rd_req_empty[c] = fifo_empty[c];
        rd_idx_sel      = rd_idx_c[c];
      end
    end
  end

  assign wr_any  = |wr_acc;
  assign rd_any  = |rd_acc;
  assign wr_addr = {wr_ch, wr_idx_sel};
  assign rd_addr = {rd_ch, rd_idx_sel};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PTRW-1:0] count_c;

    fifo_channel_ctrl #(
      .DEPTH      (DEPTH),
      .SAFE_GUARD (SAFE_GUARD)
    ) u_ctrl (
      .clk           (clk),
      .rst_n         (rst_int_n),
      .wr_acc        (wr_acc[c]),
      .rd_acc        (rd_acc[c]),
      .flush         (flush_hit[c]),
      .wr_req_full   (wr_req_full[c]),
      .rd_req_empty  (rd_req_empty[c]),
      .wr_idx_c      (wr_idx_c[c]),
      .rd_idx_c      (rd_idx_c[c]),
      .count_c       (count_c),
      .full_c        (fifo_full[c]),
      .going_full_c  (fifo_going_full[c]),
      .empty_c       (fifo_empty[c]),
      .going_empty_c (fifo_going_empty[c]),
      .overflow_err  (overflow_err[c]),
      .underflow_err (underflow_err[c])
    );

    assign fifo_count[c*PTRW +: PTRW] = count_c;
  end

  // Shared storage, one entry block of DEPTH words per channel; not reset.
  always_ff @(posedge clk) begin
    if (wr_any) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Registered read port; data_out holds between pops.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_ch    <= '0;
    end else begin
      data_out_valid <= rd_any;
      if (rd_any) begin
        data_out    <= mem[rd_addr];
        data_out_ch <= rd_ch;
      end
    end
  end

endmodule
